// File: rtl/avalon_gpio_pio_if.sv
// Avalon-MM slave bus bundle for the GPIO PIO: word address, strobes and 32-bit data.
interface avalon_gpio_pio_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, read_n, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, read_n, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/avalon_gpio_pio.sv
// Avalon-MM GPIO slave: output register with atomic set/clear, synchronised inputs with
// sticky edge capture and a maskable, registered level interrupt.
module avalon_gpio_pio #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               EDGE_TYPE   = 0,
   parameter int               SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   avalon_gpio_pio_if.slave   bus,
   input  logic [WIDTH-1:0]   in_port,
   output logic [WIDTH-1:0]   out_port,
   output logic               irq
);

   localparam logic [2:0] ADDR_OUT    = 3'd0;
   localparam logic [2:0] ADDR_IN     = 3'd1;
   localparam logic [2:0] ADDR_MASK   = 3'd2;
   localparam logic [2:0] ADDR_EDGE   = 3'd3;
   localparam logic [2:0] ADDR_OUTSET = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR = 3'd5;

   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_edgeCap;
   logic             r_irq;
   logic [31:0]      r_readdata;

   logic             w_wrEn;
   logic             w_rdEn;
   logic [WIDTH-1:0] w_wrData;
   logic [WIDTH-1:0] w_inSync;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_capClr;
   logic [WIDTH-1:0] w_outNext;
   logic [31:0]      w_rdWord;
   logic             w_unusedWrHi;

   assign w_wrEn       = bus.chipselect & ~bus.write_n;
   assign w_rdEn       = bus.chipselect & ~bus.read_n;
   assign w_wrData     = bus.writedata[WIDTH-1:0];
   assign w_unusedWrHi = ^bus.writedata;
   assign w_inSync     = r_sync[SYNC_STAGES-1];
   assign w_capClr     = (w_wrEn && bus.address == ADDR_EDGE) ? w_wrData : '0;

   // The delayed copy of the synchronised value gives one clean compare per edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= '0;
         end
         r_prev <= '0;
      end else begin
         r_sync[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_prev <= w_inSync;
      end
   end

   always_comb begin
      if (EDGE_TYPE == 0) begin
         w_edge = w_inSync & ~r_prev;
      end else if (EDGE_TYPE == 1) begin
         w_edge = ~w_inSync & r_prev;
      end else begin
         w_edge = w_inSync ^ r_prev;
      end
   end

   always_comb begin
      w_outNext = r_out;
      if (w_wrEn) begin
         case (bus.address)
            ADDR_OUT:    w_outNext = w_wrData;
            ADDR_OUTSET: w_outNext = r_out | w_wrData;
            ADDR_OUTCLR: w_outNext = r_out & ~w_wrData;
            default:     w_outNext = r_out;
         endcase
      end
   end

   // Upper readdata bits stay zero for narrow ports; write-only and reserved addresses read 0.
   always_comb begin
      w_rdWord = '0;
      case (bus.address)
         ADDR_OUT:  w_rdWord[WIDTH-1:0] = r_out;
         ADDR_IN:   w_rdWord[WIDTH-1:0] = w_inSync;
         ADDR_MASK: w_rdWord[WIDTH-1:0] = r_mask;
         ADDR_EDGE: w_rdWord[WIDTH-1:0] = r_edgeCap;
         default:   w_rdWord = '0;
      endcase
   end

   // A new edge overrides a coincident write-1-to-clear so no event is ever lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out      <= RESET_VALUE;
         r_mask     <= '0;
         r_edgeCap  <= '0;
         r_irq      <= 1'b0;
         r_readdata <= '0;
      end else begin
         r_out     <= w_outNext;
         r_edgeCap <= (r_edgeCap & ~w_capClr) | w_edge;
         r_irq     <= |(r_edgeCap & r_mask);
         if (w_wrEn && bus.address == ADDR_MASK) begin
            r_mask <= w_wrData;
         end
         if (w_rdEn) begin
            r_readdata <= w_rdWord;
         end
      end
   end

   assign bus.readdata = r_readdata;
   assign out_port     = r_out;
   assign irq          = r_irq;

endmodule

// File: tb/tb_avalon_gpio_pio.sv
// Bench for avalon_gpio_pio: an 8-bit rising-edge instance and a 32-bit any-edge instance,
// checked with fixed vectors, hand-timed edge sequences and a random run against a history model.
module tb_avalon_gpio_pio;

   localparam logic [31:0] RESET32 = 32'hC0DE_0001;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  in8;
   logic [7:0]  out8;
   logic        irq8;
   logic [31:0] in32;
   logic [31:0] out32;
   logic        irq32;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   avalon_gpio_pio_if bus8 ();
   avalon_gpio_pio_if bus32 ();

   avalon_gpio_pio #(.WIDTH(8), .RESET_VALUE(8'h00), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut8 (
      .clk(clk), .reset_n(reset_n), .bus(bus8),
      .in_port(in8), .out_port(out8), .irq(irq8)
   );

   avalon_gpio_pio #(.WIDTH(32), .RESET_VALUE(RESET32), .EDGE_TYPE(2), .SYNC_STAGES(3)) dut32 (
      .clk(clk), .reset_n(reset_n), .bus(bus32),
      .in_port(in32), .out_port(out32), .irq(irq32)
   );

   // Reference model: per-instance registers plus a history of in_port samples, newest first.
   logic [31:0] mOut  [2];
   logic [31:0] mMask [2];
   logic [31:0] mCap  [2];
   logic [31:0] mRd   [2];
   logic        mIrq  [2];
   logic [31:0] hist  [2][5];

   function automatic logic [31:0] widthMask(input int s);
      return (s == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
   endfunction

   function automatic int syncDepth(input int s);
      return (s == 0) ? 2 : 3;
   endfunction

   function automatic logic [31:0] readModel(input int s, input logic [2:0] a);
      case (a)
         3'd0:    return mOut[s];
         3'd1:    return hist[s][syncDepth(s)-1];
         3'd2:    return mMask[s];
         3'd3:    return mCap[s];
         default: return 32'h0;
      endcase
   endfunction

   task automatic modelReset();
      for (int s = 0; s < 2; s++) begin
         mOut[s]  = (s == 0) ? 32'h0 : RESET32;
         mMask[s] = '0;
         mCap[s]  = '0;
         mRd[s]   = '0;
         mIrq[s]  = 1'b0;
         for (int k = 0; k < 5; k++) hist[s][k] = '0;
      end
   endtask

   task automatic modelStep(input int s);
      logic [31:0] m, cur, prv, edgeBits, wd, inp, clr;
      logic [2:0]  a;
      logic        cs, rdn, wrn;
      int          n;
      m   = widthMask(s);
      n   = syncDepth(s);
      cur = hist[s][n-1];
      prv = hist[s][n];
      if (s == 0) begin
         edgeBits = cur & ~prv;
         a = bus8.address; cs = bus8.chipselect; rdn = bus8.read_n; wrn = bus8.write_n;
         wd = bus8.writedata & m; inp = {24'h0, in8};
      end else begin
         edgeBits = cur ^ prv;
         a = bus32.address; cs = bus32.chipselect; rdn = bus32.read_n; wrn = bus32.write_n;
         wd = bus32.writedata & m; inp = in32;
      end
      mIrq[s] = |(mCap[s] & mMask[s]);
      if (cs && !rdn) mRd[s] = readModel(s, a);
      clr = '0;
      if (cs && !wrn) begin
         case (a)
            3'd0: mOut[s]  = wd;
            3'd2: mMask[s] = wd;
            3'd3: clr      = wd;
            3'd4: mOut[s]  = mOut[s] | wd;
            3'd5: mOut[s]  = mOut[s] & ~wd;
            default: ;
         endcase
      end
      mCap[s] = (mCap[s] & ~clr) | edgeBits;
      for (int k = 4; k > 0; k--) hist[s][k] = hist[s][k-1];
      hist[s][0] = inp;
   endtask

   task automatic idleBuses();
      bus8.address = '0;  bus8.chipselect = 1'b0;  bus8.read_n = 1'b1;  bus8.write_n = 1'b1;  bus8.writedata = '0;
      bus32.address = '0; bus32.chipselect = 1'b0; bus32.read_n = 1'b1; bus32.write_n = 1'b1; bus32.writedata = '0;
   endtask

   task automatic applyStimulus(input int s, input logic [2:0] a, input bit wr, input bit rd, input logic [31:0] d);
      if (s == 0) begin
         bus8.address = a; bus8.chipselect = wr | rd; bus8.write_n = ~wr; bus8.read_n = ~rd; bus8.writedata = d;
      end else begin
         bus32.address = a; bus32.chipselect = wr | rd; bus32.write_n = ~wr; bus32.read_n = ~rd; bus32.writedata = d;
      end
   endtask

   // One clock: model advances with the inputs as driven, then outputs settle 1 ns after the edge.
   task automatic tick();
      if (!reset_n) begin
         modelReset();
      end else begin
         modelStep(0);
         modelStep(1);
      end
      @(posedge clk);
      #1;
      idleBuses();
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  addr;
      bit          wr;
      bit          rd;
      logic [31:0] wdata;
      logic [7:0]  expOut;
      logic [31:0] expRd;
   } vec_t;

   vec_t vecs[19];

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{3'd0, 1, 0, 32'h0000_00A5, 8'hA5, 32'h0};
      vecs[1]  = '{3'd0, 0, 1, 32'h0,         8'hA5, 32'hA5};
      vecs[2]  = '{3'd0, 1, 0, 32'h0000_00A0, 8'hA0, 32'hA5};
      vecs[3]  = '{3'd4, 1, 0, 32'h0000_000F, 8'hAF, 32'hA5};
      vecs[4]  = '{3'd5, 1, 0, 32'h0000_0081, 8'h2E, 32'hA5};
      vecs[5]  = '{3'd4, 0, 1, 32'h0,         8'h2E, 32'h0};
      vecs[6]  = '{3'd0, 0, 1, 32'h0,         8'h2E, 32'h2E};
      vecs[7]  = '{3'd5, 0, 1, 32'h0,         8'h2E, 32'h0};
      vecs[8]  = '{3'd1, 1, 0, 32'h0000_00FF, 8'h2E, 32'h0};
      vecs[9]  = '{3'd1, 0, 1, 32'h0,         8'h2E, 32'h0};
      vecs[10] = '{3'd0, 1, 0, 32'hFFFF_FF3C, 8'h3C, 32'h0};
      vecs[11] = '{3'd0, 0, 1, 32'h0,         8'h3C, 32'h3C};
      vecs[12] = '{3'd6, 1, 0, 32'h0000_00FF, 8'h3C, 32'h3C};
      vecs[13] = '{3'd6, 0, 1, 32'h0,         8'h3C, 32'h0};
      vecs[14] = '{3'd2, 1, 0, 32'h0000_0055, 8'h3C, 32'h0};
      vecs[15] = '{3'd2, 0, 1, 32'h0,         8'h3C, 32'h55};
      vecs[16] = '{3'd2, 1, 0, 32'h0,         8'h3C, 32'h55};
      vecs[17] = '{3'd0, 1, 1, 32'h0000_0011, 8'h11, 32'h3C};
      vecs[18] = '{3'd7, 0, 1, 32'h0,         8'h11, 32'h0};

      reset_n = 1'b0;
      in8 = '0;
      in32 = '0;
      idleBuses();
      modelReset();
      tick();
      tick();
      checkOutput("reset out8", {24'h0, out8}, 32'h0);
      checkOutput("reset rd8", bus8.readdata, 32'h0);
      checkOutput("reset irq8", {31'h0, irq8}, 32'h0);
      checkOutput("reset out32", out32, RESET32);
      checkOutput("reset rd32", bus32.readdata, 32'h0);
      checkOutput("reset irq32", {31'h0, irq32}, 32'h0);
      reset_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         applyStimulus(0, vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].wdata);
         tick();
         checkOutput($sformatf("vec%0d out", i), {24'h0, out8}, {24'h0, vecs[i].expOut});
         checkOutput($sformatf("vec%0d rd", i), bus8.readdata, vecs[i].expRd);
      end

      // Rising edge on bit 3: capture lands on the third edge, irq one edge later.
      applyStimulus(0, 3'd2, 1, 0, 32'h08); tick();
      in8 = 8'h08;
      tick(); tick();
      checkOutput("t3 irq early", {31'h0, irq8}, 32'h0);
      applyStimulus(0, 3'd3, 0, 1, 0); tick();
      checkOutput("t3 cap before edge3", bus8.readdata, 32'h0);
      checkOutput("t3 irq edge3", {31'h0, irq8}, 32'h0);
      applyStimulus(0, 3'd3, 0, 1, 0); tick();
      checkOutput("t3 cap set", bus8.readdata, 32'h08);
      checkOutput("t3 irq set", {31'h0, irq8}, 32'h1);
      applyStimulus(0, 3'd3, 1, 0, 32'h08); tick();
      checkOutput("t3 irq lag after clear", {31'h0, irq8}, 32'h1);
      applyStimulus(0, 3'd3, 0, 1, 0); tick();
      checkOutput("t3 cap cleared", bus8.readdata, 32'h0);
      checkOutput("t3 irq cleared", {31'h0, irq8}, 32'h0);
      in8 = 8'h00;
      repeat (4) tick();
      applyStimulus(0, 3'd3, 0, 1, 0); tick();
      checkOutput("t3 falling ignored", bus8.readdata, 32'h0);
      checkOutput("t3 falling irq", {31'h0, irq8}, 32'h0);

      // Clear coinciding with a fresh capture on the same bit.
      in8 = 8'h08;
      repeat (3) tick();
      applyStimulus(0, 3'd3, 0, 1, 0); tick();
      checkOutput("t4 first cap", bus8.readdata, 32'h08);
      checkOutput("t4 first irq", {31'h0, irq8}, 32'h1);
      in8 = 8'h00;
      repeat (4) tick();
      in8 = 8'h08;
      tick(); tick();
      applyStimulus(0, 3'd3, 1, 0, 32'h08); tick();
      checkOutput("t4 irq at collision", {31'h0, irq8}, 32'h1);
      applyStimulus(0, 3'd3, 0, 1, 0); tick();
      checkOutput("t4 set wins", bus8.readdata, 32'h08);
      checkOutput("t4 irq held", {31'h0, irq8}, 32'h1);
      applyStimulus(0, 3'd3, 1, 0, 32'h08); tick(); tick();
      checkOutput("t4 irq after clear", {31'h0, irq8}, 32'h0);

      // Capture while masked, then unmask.
      applyStimulus(0, 3'd2, 1, 0, 32'h00); tick();
      in8 = 8'h09;
      repeat (4) tick();
      checkOutput("t5 masked irq", {31'h0, irq8}, 32'h0);
      applyStimulus(0, 3'd3, 0, 1, 0); tick();
      checkOutput("t5 masked cap", bus8.readdata, 32'h01);
      applyStimulus(0, 3'd2, 1, 0, 32'hFF); tick();
      checkOutput("t5 irq mask edge", {31'h0, irq8}, 32'h0);
      tick();
      checkOutput("t5 irq unmasked", {31'h0, irq8}, 32'h1);

      // Asynchronous reset in the middle of activity.
      applyStimulus(0, 3'd0, 1, 0, 32'h5A);
      applyStimulus(1, 3'd0, 1, 0, 32'h1234_5678);
      tick();
      applyStimulus(0, 3'd0, 0, 1, 0);
      applyStimulus(1, 3'd0, 0, 1, 0);
      tick();
      checkOutput("t6 pre out8", {24'h0, out8}, 32'h5A);
      checkOutput("t6 pre rd8", bus8.readdata, 32'h5A);
      checkOutput("t6 pre out32", out32, 32'h1234_5678);
      #1;
      reset_n = 1'b0;
      #2;
      checkOutput("t6 async out8", {24'h0, out8}, 32'h0);
      checkOutput("t6 async rd8", bus8.readdata, 32'h0);
      checkOutput("t6 async irq8", {31'h0, irq8}, 32'h0);
      checkOutput("t6 async out32", out32, RESET32);
      checkOutput("t6 async rd32", bus32.readdata, 32'h0);
      tick(); tick();
      reset_n = 1'b1;
      repeat (3) tick();
      applyStimulus(0, 3'd3, 0, 1, 0);
      applyStimulus(1, 3'd0, 0, 1, 0);
      tick();
      checkOutput("t6 high input after reset", bus8.readdata, 32'h09);
      checkOutput("t6 rd32 reset value", bus32.readdata, RESET32);
      checkOutput("t6 irq8 mask lost", {31'h0, irq8}, 32'h0);

      // Wide any-edge instance: bit 31 toggled both ways gives two captures.
      in32 = 32'h8000_0000;
      repeat (4) tick();
      applyStimulus(1, 3'd3, 0, 1, 0); tick();
      checkOutput("w32 rise cap", bus32.readdata, 32'h8000_0000);
      applyStimulus(1, 3'd3, 1, 0, 32'h8000_0000); tick();
      in32 = 32'h0;
      applyStimulus(1, 3'd3, 0, 1, 0); tick();
      checkOutput("w32 cleared", bus32.readdata, 32'h0);
      repeat (3) tick();
      applyStimulus(1, 3'd3, 0, 1, 0); tick();
      checkOutput("w32 fall cap", bus32.readdata, 32'h8000_0000);

      // Random traffic on both instances against the model.
      for (int c = 0; c < 400; c++) begin
         for (int s = 0; s < 2; s++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)       applyStimulus(s, 3'($urandom_range(0, 7)), 1, 0, $urandom);
            else if (r < 6)  applyStimulus(s, 3'($urandom_range(0, 7)), 0, 1, 0);
            else if (r == 6) applyStimulus(s, 3'($urandom_range(0, 7)), 1, 1, $urandom);
         end
         if ($urandom_range(0, 3) == 0) in8 = 8'($urandom);
         if ($urandom_range(0, 3) == 0) in32 = in32 ^ (32'h1 << $urandom_range(0, 31));
         tick();
         checkOutput($sformatf("rnd%0d out8", c), {24'h0, out8}, mOut[0]);
         checkOutput($sformatf("rnd%0d rd8", c), bus8.readdata, mRd[0]);
         checkOutput($sformatf("rnd%0d irq8", c), {31'h0, irq8}, {31'h0, mIrq[0]});
         checkOutput($sformatf("rnd%0d out32", c), out32, mOut[1]);
         checkOutput($sformatf("rnd%0d rd32", c), bus32.readdata, mRd[1]);
         checkOutput($sformatf("rnd%0d irq32", c), {31'h0, irq32}, {31'h0, mIrq[1]});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
